// File: rtl/score_pkg.sv
// score_pkg: grade/state encodings, multiplier type and saturating add shared by score_accumulator.
package score_pkg;
   typedef enum logic [1:0] {NONE = 2'b00, GOOD = 2'b01, PERFECT = 2'b10, MISS = 2'b11} grade_t;
   typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;
   localparam int MULT_W = 3;
   typedef logic [MULT_W-1:0] mult_t;
   // Operands are widened to 33 bits so the carry is visible before clamping to 2^w-1.
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int unsigned w);
      logic [32:0] s, lim;
      s = {1'b0, a} + {1'b0, b};
      lim = (33'd1 << w) - 33'd1;
      return (s > lim) ? lim[31:0] : s[31:0];
   endfunction
endpackage

// File: rtl/score_accumulator_grade_tally.sv
// grade_tally: stage 1, registered per-frame perfect/good/miss lane counts with a valid flag.
module grade_tally
   import score_pkg::*;
#(
   parameter  int N_NOTES = 46,
   localparam int CNT_W   = $clog2(N_NOTES + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr_i,
   input  logic                 en_i,
   input  logic [2*N_NOTES-1:0] hit_grade_i,
   output logic [CNT_W-1:0]     p_o,
   output logic [CNT_W-1:0]     g_o,
   output logic [CNT_W-1:0]     m_o,
   output logic                 valid_o
);
   logic [CNT_W-1:0] p_d, g_d, m_d, p_q, g_q, m_q;
   logic             valid_q;
   always_comb begin
      p_d = '0;
      g_d = '0;
      m_d = '0;
      for (int i = 0; i < N_NOTES; i++) begin
         p_d = p_d + CNT_W'(grade_t'(hit_grade_i[2*i +: 2]) == PERFECT);
         g_d = g_d + CNT_W'(grade_t'(hit_grade_i[2*i +: 2]) == GOOD);
         m_d = m_d + CNT_W'(grade_t'(hit_grade_i[2*i +: 2]) == MISS);
      end
   end
   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         p_q     <= '0;
         g_q     <= '0;
         m_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         p_q     <= p_d;
         g_q     <= g_d;
         m_q     <= m_d;
         valid_q <= en_i;
      end
   end
   assign p_o     = p_q;
   assign g_o     = g_q;
   assign m_o     = m_q;
   assign valid_o = valid_q;
endmodule

// File: rtl/score_accumulator.sv
// score_accumulator: two-stage frame scorer with combo multiplier and saturating totals.
// Define GRADE_COUNT_EN to add saturating perfect/good/miss counters.
module score_accumulator
   import score_pkg::*;
#(
   parameter int N_NOTES     = 46,
   parameter int SCORE_W     = 14,
   parameter int COMBO_W     = 10,
   parameter int PERFECT_PTS = 3,
   parameter int GOOD_PTS    = 1,
   parameter int COMBO_STEP  = 10,
   parameter int MAX_MULT    = 4
) (
   input  logic                 frame_clk,
   input  logic                 Reset,
   input  logic                 song_start,
   input  logic                 song_end,
   input  logic [2*N_NOTES-1:0] hit_grade,
   output logic [SCORE_W-1:0]   total_score,
   output logic [COMBO_W-1:0]   combo,
   output logic [COMBO_W-1:0]   max_combo,
   output mult_t                multiplier,
   output logic                 playing,
   output logic                 done
`ifdef GRADE_COUNT_EN
   ,
   output logic [15:0]          perfect_count,
   output logic [15:0]          good_count,
   output logic [15:0]          miss_count
`endif
);
   localparam int CNT_W = $clog2(N_NOTES + 1);
   state_t             state_q;
   logic               playing_q, done_q, v1;
   logic [CNT_W-1:0]   p, g, m;
   logic [31:0]        base;
   logic [SCORE_W-1:0] score_d, score_q;
   logic [COMBO_W-1:0] combo_d, combo_q, max_d, max_q;
   mult_t              mult_d, mult_q;
`ifdef GRADE_COUNT_EN
   logic [15:0]        pc_d, gc_d, mc_d, pc_q, gc_q, mc_q;
`endif
   function automatic mult_t mult_of(input logic [COMBO_W-1:0] c);
      int unsigned q;
      q = 32'(c) / 32'(COMBO_STEP) + 32'd1;
      return (q >= 32'(MAX_MULT)) ? mult_t'(MAX_MULT) : mult_t'(q);
   endfunction
   grade_tally #(.N_NOTES(N_NOTES)) u_tally (
      .clk        (frame_clk),
      .rst        (Reset),
      .clr_i      (song_start),
      .en_i       (state_q == PLAY && !song_end),
      .hit_grade_i(hit_grade),
      .p_o        (p),
      .g_o        (g),
      .m_o        (m),
      .valid_o    (v1)
   );
   // mult_q always equals mult_of(combo_q), so it is the pre-update multiplier for this frame.
   always_comb begin
      base    = 32'(p) * 32'(PERFECT_PTS) + 32'(g) * 32'(GOOD_PTS);
      score_d = SCORE_W'(sat_add(32'(score_q), base * 32'(mult_q), SCORE_W));
      combo_d = (m != '0) ? '0 : COMBO_W'(sat_add(32'(combo_q), 32'(p) + 32'(g), COMBO_W));
      max_d   = (combo_d > max_q) ? combo_d : max_q;
      mult_d  = mult_of(combo_d);
`ifdef GRADE_COUNT_EN
      pc_d    = 16'(sat_add(32'(pc_q), 32'(p), 16));
      gc_d    = 16'(sat_add(32'(gc_q), 32'(g), 16));
      mc_d    = 16'(sat_add(32'(mc_q), 32'(m), 16));
`endif
   end
   always_ff @(posedge frame_clk) begin
      if (Reset || song_start) begin
         score_q   <= '0;
         combo_q   <= '0;
         max_q     <= '0;
         mult_q    <= mult_t'(1);
         state_q   <= Reset ? IDLE : PLAY;
         playing_q <= !Reset;
         done_q    <= 1'b0;
`ifdef GRADE_COUNT_EN
         pc_q      <= '0;
         gc_q      <= '0;
         mc_q      <= '0;
`endif
      end else begin
         if (v1) begin
            score_q <= score_d;
            combo_q <= combo_d;
            max_q   <= max_d;
            mult_q  <= mult_d;
`ifdef GRADE_COUNT_EN
            pc_q    <= pc_d;
            gc_q    <= gc_d;
            mc_q    <= mc_d;
`endif
         end
         if (state_q == PLAY && song_end) begin
            state_q   <= DONE;
            playing_q <= 1'b0;
            done_q    <= 1'b1;
         end
      end
   end
   assign total_score = score_q;
   assign combo       = combo_q;
   assign max_combo   = max_q;
   assign multiplier  = mult_q;
   assign playing     = playing_q;
   assign done        = done_q;
`ifdef GRADE_COUNT_EN
   assign perfect_count = pc_q;
   assign good_count    = gc_q;
   assign miss_count    = mc_q;
`endif
endmodule
